clkgen_div: RTL and testbench
=============================

CLKGEN_DIV -- requirements
Module: clkgen_div

Interface
REQ-001 SHALL have parameter NUM_CLOCKS, default 4: number of output clock channels, range 1..8.
REQ-002 SHALL have parameter DIV_W, default 16: width of divide and phase fields.
REQ-003 SHALL have parameter DEFAULT_DIV, default 5: divide ratio of every channel after reset (10 MHz from 50 MHz refclk).
REQ-004 SHALL have parameter LOCK_CYCLES, default 16: settle cycles before locked asserts, range 1..2^16-1.
REQ-005 SHALL have port refclk, input, 1 bit: the single clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset; synchronous, active-high.
REQ-007 SHALL have port cfg_valid, input, 1 bit: configuration request valid.
REQ-008 SHALL have port cfg_ready, output, 1 bit: configuration request accepted when high with cfg_valid.
REQ-009 SHALL have port cfg_chan, input, clog2(NUM_CLOCKS) bits: target channel.
REQ-010 SHALL have port cfg_div, input, DIV_W bits: new divide ratio.
REQ-011 SHALL have port cfg_phase, input, DIV_W bits: new phase offset in refclk cycles.
REQ-012 SHALL have port cfg_sync, input, 1 bit: if set, all channels restart at their phase when the update is applied.
REQ-013 SHALL have port outclk, output, NUM_CLOCKS bits: divided clocks, each driven directly from a flop.
REQ-014 SHALL have port outclk_en, output, NUM_CLOCKS bits: one-cycle clock-enable strobes, each driven directly from a flop.
REQ-015 SHALL have port locked, output, 1 bit: all channels running at their configured ratio and settled.

Function
REQ-016 SHALL keep per channel a counter cnt_i over 0..div_i-1, incrementing each cycle and wrapping from div_i-1 to 0.
REQ-017 SHALL clamp any div value below 2 to 2; phase values >= div SHALL be treated as 0.
REQ-018 SHALL drive outclk[i]=1 exactly in cycles where cnt_i < floor(div_i/2); div=5 gives 2 high, 3 low; div=4 gives 2/2.
REQ-019 SHALL drive outclk_en[i]=1 exactly in cycles where cnt_i==0.
REQ-020 SHALL implement a controller FSM with states HOLD (rst high), SETTLE, LOCKED, PENDING.
REQ-021 SHALL go HOLD->SETTLE on the first cycle with rst low, load the settle counter, and hold cfg_ready=0 and locked=0.
REQ-022 SHALL go SETTLE->LOCKED when the settle counter reaches LOCK_CYCLES, so locked is first 1 exactly LOCK_CYCLES cycles after the first rst-low cycle.
REQ-023 SHALL drive cfg_ready=1 only in LOCKED; a transfer occurs when cfg_valid and cfg_ready are both high.
REQ-024 SHALL on transfer latch chan/div/phase/sync into a single pending slot, go to PENDING, and drive locked=0 from the next cycle.
REQ-025 SHALL in PENDING apply the update in the cycle after the target channel has cnt==div_old-1: that channel then loads cnt=phase_new and runs at div_new, with no outclk high or low pulse shorter than min(floor(div_old/2), floor(div_new/2)).
REQ-026 SHALL, when cfg_sync is set, load every channel's cnt with its own phase in the same apply cycle.
REQ-027 SHALL go PENDING->SETTLE in the apply cycle and restart the settle counter; locked re-asserts LOCK_CYCLES cycles after the apply cycle.
REQ-028 SHALL ignore cfg_valid outside LOCKED: no transfer, no state change.
REQ-029 SHALL leave non-target channels running uninterrupted during a non-sync update.

Reset
REQ-030 SHALL, while rst is high, hold outclk=0, outclk_en=0, locked=0, cfg_ready=0, all cnt_i=0, all div_i=DEFAULT_DIV, all phase_i=0, pending slot empty, FSM in HOLD.
REQ-031 SHALL on rst asserted in any state, including PENDING, discard the pending update and take the REQ-030 values on the next edge.

Structure
REQ-032 SHALL place the FSM state enum, DEFAULT_DIV and LOCK_CYCLES defaults, and the div/phase clamp function in package clkgen_pkg.
REQ-033 SHALL instantiate one sub-module clkgen_div_chan per channel, holding the counter, the div/phase registers, the apply logic and the output flops.

Verification
REQ-034 SHALL check reset release with defaults: outclk[0] period 5 (2 high / 3 low); outclk_en once per 5 cycles; locked first 1 at cycle 16.
REQ-035 SHALL check cfg chan=1, div=8, phase=0 mid-run: locked drops the next cycle; switch occurs only at the ch1 wrap; ch0 shows no disturbance; locked returns 16 cycles after the apply cycle.
REQ-036 SHALL check cfg chan=0, div=6, phase=3, sync=1: in the apply cycle all channels load their phases; ch0 outclk_en pulses exactly 3 cycles later.
REQ-037 SHALL check cfg_div=0 and cfg_div=1: both run as div=2 (1 high / 1 low); phase=7 with div=4 behaves as phase 0.
REQ-038 SHALL check cfg_valid held high during SETTLE and PENDING: no transfer occurs; the request transfers on the first LOCKED cycle.
REQ-039 SHALL check rst asserted one cycle after a transfer: the pending update is lost, all outputs are 0, and a restart gives defaults.

Source files
------------

// File: rtl/clkgen_pkg.sv
// clkgen_pkg: controller state encoding, reset defaults and div/phase clamping shared by clkgen_div
package clkgen_pkg;
   typedef enum logic [1:0] {HOLD, SETTLE, LOCKED, PENDING} state_e;
   localparam int DEFAULT_DIV_P = 5;
   localparam int LOCK_CYCLES_P = 16;
   function automatic logic [31:0] clamp_div(input logic [31:0] d);
      return (d < 32'd2) ? 32'd2 : d;
   endfunction
   function automatic logic [31:0] clamp_phase(input logic [31:0] p, input logic [31:0] d);
      return (p >= d) ? 32'd0 : p;
   endfunction
endpackage

// File: rtl/clkgen_div_chan.sv
// clkgen_div_chan: one divider channel with counter, div/phase registers, update apply and output flops
module clkgen_div_chan
   import clkgen_pkg::*;
#(
   parameter int DIV_W       = 16,
   parameter int DEFAULT_DIV = DEFAULT_DIV_P
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             run_i,
   input  logic             apply_i,
   input  logic             sync_i,
   input  logic [DIV_W-1:0] div_i,
   input  logic [DIV_W-1:0] phase_i,
   output logic             wrap_o,
   output logic             outclk_o,
   output logic             en_o
);
   logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, phase_q, phase_d, div_n, phase_n;
   logic outclk_q, en_q;
   assign outclk_o = outclk_q;
   assign en_o     = en_q;
   // next counter: hold until running, then a pending update or sync restart overrides the normal wrap
   always_comb begin
      div_n   = DIV_W'(clamp_div(32'(div_i)));
      phase_n = DIV_W'(clamp_phase(32'(phase_i), 32'(div_n)));
      wrap_o  = cnt_q == div_q - DIV_W'(1);
      div_d   = apply_i ? div_n : div_q;
      phase_d = apply_i ? phase_n : phase_q;
      cnt_d   = !run_i ? cnt_q : apply_i ? phase_n : sync_i ? phase_q : wrap_o ? '0 : cnt_q + DIV_W'(1);
   end
   // outputs are registered from the next count so each flop reflects the count of its own cycle
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q    <= '0;
         div_q    <= DIV_W'(clamp_div(32'(DEFAULT_DIV)));
         phase_q  <= '0;
         outclk_q <= 1'b0;
         en_q     <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         phase_q  <= phase_d;
         outclk_q <= cnt_d < (div_d >> 1);
         en_q     <= cnt_d == '0;
      end
   end
endmodule

// File: rtl/clkgen_div.sv
// clkgen_div: multi-channel clock divider with glitch-free reconfiguration and lock indication
module clkgen_div
   import clkgen_pkg::*;
#(
   parameter int NUM_CLOCKS  = 4,
   parameter int DIV_W       = 16,
   parameter int DEFAULT_DIV = DEFAULT_DIV_P,
   parameter int LOCK_CYCLES = LOCK_CYCLES_P,
   localparam int CW         = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
   input  logic                  refclk,
   input  logic                  rst,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [CW-1:0]         cfg_chan,
   input  logic [DIV_W-1:0]      cfg_div,
   input  logic [DIV_W-1:0]      cfg_phase,
   input  logic                  cfg_sync,
   output logic [NUM_CLOCKS-1:0] outclk,
   output logic [NUM_CLOCKS-1:0] outclk_en,
   output logic                  locked
);
   state_e           state_q;
   logic [15:0]      settle_q;
   logic             lock_q;
   logic [CW-1:0]    chan_q;
   logic [DIV_W-1:0] pdiv_q, pphase_q;
   logic             psync_q;
   logic [2**CW-1:0] wrap_v;
   logic             apply;
   assign cfg_ready = lock_q;
   assign locked    = lock_q;
   assign apply     = (state_q == PENDING) && wrap_v[chan_q];
   for (genvar g = 0; g < 2**CW; g++) begin : g_chan
      if (g < NUM_CLOCKS) begin : g_live
         clkgen_div_chan #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) u_chan (
            .clk_i   (refclk),
            .rst_i   (rst),
            .run_i   (state_q != HOLD),
            .apply_i (apply && chan_q == CW'(g)),
            .sync_i  (apply && psync_q),
            .div_i   (pdiv_q),
            .phase_i (pphase_q),
            .wrap_o  (wrap_v[g]),
            .outclk_o(outclk[g]),
            .en_o    (outclk_en[g])
         );
      end else begin : g_pad
         assign wrap_v[g] = 1'b1;
      end
   end
   // controller: settle after reset or update, accept one request when locked, apply it at the target wrap
   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q  <= HOLD;
         settle_q <= '0;
         lock_q   <= 1'b0;
         chan_q   <= '0;
         pdiv_q   <= '0;
         pphase_q <= '0;
         psync_q  <= 1'b0;
      end else begin
         case (state_q)
            HOLD: begin
               state_q  <= SETTLE;
               settle_q <= 16'd1;
            end
            SETTLE: begin
               if (settle_q == 16'(LOCK_CYCLES)) begin
                  state_q <= LOCKED;
                  lock_q  <= 1'b1;
               end else settle_q <= settle_q + 16'd1;
            end
            LOCKED: begin
               if (cfg_valid) begin
                  state_q  <= PENDING;
                  lock_q   <= 1'b0;
                  chan_q   <= cfg_chan;
                  pdiv_q   <= cfg_div;
                  pphase_q <= cfg_phase;
                  psync_q  <= cfg_sync;
               end
            end
            PENDING: begin
               if (apply) begin
                  state_q  <= SETTLE;
                  settle_q <= 16'd1;
               end
            end
            default: state_q <= HOLD;
         endcase
      end
   end
endmodule

// File: tb/tb_clkgen_div.sv
// tb_clkgen_div: randomized and directed stimulus checked every cycle against a time-based reference model
module tb_clkgen_div;
   localparam int N = 4, W = 16, DD = 5, LC = 16;
   logic refclk = 1'b0, rst = 1'b1, cfg_valid = 1'b0, cfg_sync = 1'b0;
   logic [1:0] cfg_chan = '0;
   logic [W-1:0] cfg_div = '0, cfg_phase = '0;
   logic cfg_ready, locked;
   logic [N-1:0] outclk, outclk_en;
   int n_chk = 0, n_fail = 0;
   int now = 0, lock_at = 0;
   bit m_rst = 1'b1, pend = 1'b0, p_sync = 1'b0;
   int p_chan, p_div, p_ph;
   int m_div[N], m_ph[N], m_t0[N], m_st[N];
   always #5 refclk = ~refclk;
   clkgen_div #(.NUM_CLOCKS(N), .DIV_W(W), .DEFAULT_DIV(DD), .LOCK_CYCLES(LC)) dut (
      .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_chan(cfg_chan), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_sync(cfg_sync),
      .outclk(outclk), .outclk_en(outclk_en), .locked(locked)
   );
   function automatic int cdiv(int d);
      return d < 2 ? 2 : d;
   endfunction
   function automatic int cph(int p, int d);
      return p >= d ? 0 : p;
   endfunction
   // channel count at cycle t: elapsed cycles since its last (re)start, modulo its ratio
   function automatic int mcnt(int i, int t);
      return (m_st[i] + t - m_t0[i]) % m_div[i];
   endfunction
   function automatic bit m_locked();
      return !m_rst && !pend && now >= lock_at;
   endfunction
   task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, now, act, exp);
      end
   endtask
   task automatic model_edge();
      bit was_locked;
      int prev;
      was_locked = m_locked();
      prev = now;
      now++;
      if (rst) begin
         m_rst = 1'b1;
         pend = 1'b0;
         for (int i = 0; i < N; i++) begin
            m_div[i] = DD;
            m_ph[i] = 0;
         end
      end else if (m_rst) begin
         m_rst = 1'b0;
         lock_at = now + LC;
         for (int i = 0; i < N; i++) begin
            m_t0[i] = now;
            m_st[i] = 0;
         end
      end else if (pend && mcnt(p_chan, prev) == m_div[p_chan] - 1) begin
         for (int i = 0; i < N; i++) begin
            if (i == p_chan) begin
               m_div[i] = cdiv(p_div);
               m_ph[i] = cph(p_ph, m_div[i]);
               m_st[i] = m_ph[i];
               m_t0[i] = now;
            end else if (p_sync) begin
               m_st[i] = m_ph[i];
               m_t0[i] = now;
            end
         end
         pend = 1'b0;
         lock_at = now + LC;
      end else if (was_locked && cfg_valid) begin
         pend = 1'b1;
         p_chan = int'(cfg_chan);
         p_div = int'(cfg_div);
         p_ph = int'(cfg_phase);
         p_sync = cfg_sync;
      end
   endtask
   task automatic compare();
      logic [N-1:0] eo, ee;
      int c;
      eo = '0;
      ee = '0;
      if (!m_rst)
         for (int i = 0; i < N; i++) begin
            c = mcnt(i, now);
            eo[i] = c < m_div[i] / 2;
            ee[i] = c == 0;
         end
      check("outclk", 32'(outclk), 32'(eo));
      check("outclk_en", 32'(outclk_en), 32'(ee));
      check("locked", 32'(locked), 32'(m_locked()));
      check("cfg_ready", 32'(cfg_ready), 32'(m_locked()));
   endtask
   task automatic step();
      @(posedge refclk);
      model_edge();
      #1;
      compare();
   endtask
   task automatic idle(int n);
      repeat (n) step();
   endtask
   task automatic req(int c, int d, int p, bit s);
      bit done;
      done = 1'b0;
      cfg_chan = 2'(c);
      cfg_div = W'(d);
      cfg_phase = W'(p);
      cfg_sync = s;
      cfg_valid = 1'b1;
      for (int k = 0; k < 300 && !done; k++) begin
         done = m_locked();
         step();
      end
      cfg_valid = 1'b0;
      check("req_done", 32'(done), 32'd1);
   endtask
   initial begin
      idle(3);
      rst = 1'b0;
      idle(40);
      req(1, 8, 0, 1'b0);
      idle(40);
      req(0, 6, 3, 1'b1);
      idle(40);
      req(2, 0, 0, 1'b0);
      idle(30);
      req(3, 1, 0, 1'b0);
      idle(30);
      req(0, 4, 7, 1'b0);
      idle(30);
      cfg_chan = 2'd2;
      cfg_div = W'(3);
      cfg_phase = W'(1);
      cfg_sync = 1'b0;
      cfg_valid = 1'b1;
      idle(120);
      cfg_valid = 1'b0;
      idle(20);
      req(1, 9, 2, 1'b0);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(40);
      for (int k = 0; k < 3000; k++) begin
         cfg_valid = ($urandom % 8) == 0;
         cfg_chan = 2'($urandom % N);
         cfg_div = W'($urandom % 13);
         cfg_phase = W'($urandom % 16);
         cfg_sync = ($urandom % 3) == 0;
         rst = ($urandom % 600) == 0;
         step();
         if (rst) begin
            step();
            rst = 1'b0;
         end
      end
      cfg_valid = 1'b0;
      rst = 1'b0;
      idle(40);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
